// File: rtl/lotr_pkg.sv
// Shared VGA read-side constants and types: 640x480@60 timing, frame buffer geometry, RGB pixel struct.
package lotr_pkg;

  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;

  localparam int VGA_WORDS_PER_LINE = 20;
  localparam int VGA_ADDR_W         = 14;
  localparam int VGA_CNT_W          = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } t_vga_rgb;

endpackage

// File: rtl/vga_fetch_ctrl_if.sv
// Frame buffer read port plus VGA DAC pins; TestPatSel exists only with LOTR_VGA_TEST_PATTERN_EN.
interface vga_fetch_ctrl_if;
  import lotr_pkg::*;

  logic [VGA_ADDR_W-1:0] RdAddress;
  logic [31:0]           RdData;
  logic [3:0]            VgaR;
  logic [3:0]            VgaG;
  logic [3:0]            VgaB;
  logic                  HSync;
  logic                  VSync;
  logic                  FrameStart;
`ifdef LOTR_VGA_TEST_PATTERN_EN
  logic                  TestPatSel;

  modport master (output RdAddress, VgaR, VgaG, VgaB, HSync, VSync, FrameStart,
                  input  RdData, TestPatSel);
  modport slave  (input  RdAddress, VgaR, VgaG, VgaB, HSync, VSync, FrameStart,
                  output RdData, TestPatSel);
`else
  modport master (output RdAddress, VgaR, VgaG, VgaB, HSync, VSync, FrameStart,
                  input  RdData);
  modport slave  (input  RdAddress, VgaR, VgaG, VgaB, HSync, VSync, FrameStart,
                  output RdData);
`endif

endinterface

// File: rtl/vga_sync_gen.sv
// Pixel/line counters with the raw (stage-0) active window and active-low sync levels.
module vga_sync_gen
  import lotr_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [VGA_CNT_W-1:0] hcnt,
  output logic [VGA_CNT_W-1:0] vcnt,
  output logic                 active,
  output logic                 hsync_raw,
  output logic                 vsync_raw
);

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int HS1 = HS0 + H_SYNC;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int VS1 = VS0 + V_SYNC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == VGA_CNT_W'(HT - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VGA_CNT_W'(VT - 1)) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign active    = (hcnt < VGA_CNT_W'(H_ACTIVE)) && (vcnt < VGA_CNT_W'(V_ACTIVE));
  assign hsync_raw = !((hcnt >= VGA_CNT_W'(HS0)) && (hcnt < VGA_CNT_W'(HS1)));
  assign vsync_raw = !((vcnt >= VGA_CNT_W'(VS0)) && (vcnt < VGA_CNT_W'(VS1)));

endmodule

// File: rtl/vga_fetch_ctrl.sv
// VGA display reader: word fetch from the frame buffer and 1bpp -> RGB pipeline (2 QClk latency).
// Optional checkerboard source selected by macro LOTR_VGA_TEST_PATTERN_EN.
module vga_fetch_ctrl
  import lotr_pkg::*;
#(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic             QClk,
  input  logic             RstQnnnH,
  vga_fetch_ctrl_if.master bus
);

  logic [VGA_CNT_W-1:0]  hcnt, vcnt;
  logic                  active, hsync_raw, vsync_raw, first_px;
  logic [VGA_ADDR_W-1:0] vcnt_w, line_base;

  logic [4:0] h_p1;
  logic       vld_p1, hsync_p1, vsync_p1, frame_p1, pix_p1;
  t_vga_rgb   rgb_p2;
  logic       hsync_p2, vsync_p2, frame_p2;

  function automatic t_vga_rgb pixel_rgb(input logic vld, input logic pix);
    if (!vld) return '0;
    return pix ? t_vga_rgb'(FG_COLOR) : t_vga_rgb'(BG_COLOR);
  endfunction

  vga_sync_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_sync (
    .clk       (QClk),
    .rst       (RstQnnnH),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  assign first_px = (hcnt == '0) && (vcnt == '0);

  // Stage 0: word address, constant over each 32-pixel group; x20 built as x16 + x4
  assign vcnt_w    = VGA_ADDR_W'(vcnt);
  assign line_base = (vcnt_w << 4) + (vcnt_w << 2);
  assign bus.RdAddress = active ? line_base + VGA_ADDR_W'(hcnt[9:5]) : '0;

  // Stage 1: RdData arrives here, aligned with the registered pixel index
  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      h_p1     <= '0;
      vld_p1   <= 1'b0;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      frame_p1 <= 1'b0;
    end else begin
      h_p1     <= hcnt[4:0];
      vld_p1   <= active;
      hsync_p1 <= hsync_raw;
      vsync_p1 <= vsync_raw;
      frame_p1 <= first_px;
    end
  end

`ifdef LOTR_VGA_TEST_PATTERN_EN
  logic v3_p1;

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) v3_p1 <= 1'b0;
    else          v3_p1 <= vcnt[3];
  end

  always_comb begin
    pix_p1 = bus.RdData[h_p1];
    if (bus.TestPatSel) pix_p1 = h_p1[3] ^ v3_p1;
  end
`else
  always_comb begin
    pix_p1 = bus.RdData[h_p1];
  end
`endif

  // Stage 2: pin registers; blanking forced black whatever RdData holds
  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      rgb_p2   <= '0;
      hsync_p2 <= 1'b1;
      vsync_p2 <= 1'b1;
      frame_p2 <= 1'b0;
    end else begin
      rgb_p2   <= pixel_rgb(vld_p1, pix_p1);
      hsync_p2 <= hsync_p1;
      vsync_p2 <= vsync_p1;
      frame_p2 <= frame_p1;
    end
  end

  assign bus.VgaR       = rgb_p2.r;
  assign bus.VgaG       = rgb_p2.g;
  assign bus.VgaB       = rgb_p2.b;
  assign bus.HSync      = hsync_p2;
  assign bus.VSync      = vsync_p2;
  assign bus.FrameStart = frame_p2;

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Directed bench for vga_fetch_ctrl with a shortened vertical frame (24 active lines, 31 total).
module tb_vga_fetch_ctrl;

  localparam int VA    = 24;
  localparam int VFP   = 2;
  localparam int VS    = 2;
  localparam int VBP   = 3;
  localparam int LINE  = 800;
  localparam int FRAME = LINE * (VA + VFP + VS + VBP);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        force_ones = 1'b0;
  logic [31:0] rd_data = '0;
  logic [31:0] mem [0:9599];
  logic [11:0] rgb;
  int          n_cmp = 0;
  int          n_bad = 0;

  vga_fetch_ctrl_if bus();

  vga_fetch_ctrl #(.V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)) dut (
    .QClk     (clk),
    .RstQnnnH (rst),
    .bus      (bus)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (force_ones)                       rd_data <= '1;
    else if (int'(bus.RdAddress) < 9600)  rd_data <= mem[bus.RdAddress];
    else                                  rd_data <= '0;
  end

  assign bus.RdData = rd_data;
  assign rgb = {bus.VgaR, bus.VgaG, bus.VgaB};

`ifdef LOTR_VGA_TEST_PATTERN_EN
  logic tps = 1'b0;
  assign bus.TestPatSel = tps;
`endif

  // Leaves the bench in cycle 0: counters at (0,0), next posedge is cycle 1.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rgb !== 12'h000)       begin n_bad++; $display("FAIL rst_rgb got %h want 000", rgb); end
    n_cmp++; if (bus.HSync !== 1'b1)    begin n_bad++; $display("FAIL rst_hsync got %b want 1", bus.HSync); end
    n_cmp++; if (bus.VSync !== 1'b1)    begin n_bad++; $display("FAIL rst_vsync got %b want 1", bus.VSync); end
    n_cmp++; if (bus.FrameStart !== 1'b0) begin n_bad++; $display("FAIL rst_fs got %b want 0", bus.FrameStart); end
    n_cmp++; if (bus.RdAddress !== 14'd0) begin n_bad++; $display("FAIL rst_addr got %0d want 0", bus.RdAddress); end
  endtask

  task automatic test_timing_and_fetch();
    int fs_n = 0, fs_c0 = -1, fs_c1 = -1;
    int hs_f1 = -1, hs_f2 = -1, hs_low = 0, vs_f = -1, vs_low = 0, addr_bad = 0;
    int h, v, ea;
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    int a_cyc [6] = '{31, 32, 639, 640, 800, 23*800+639};
    int a_exp [6] = '{0, 1, 19, 0, 20, 479};
    int p_cyc [6] = '{2, 3, 33, 34, 65, 802};
    logic [11:0] p_exp [6] = '{12'hFFF, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000};
    force_ones = 1'b0;
    do_reset();
    for (int c = 1; c <= FRAME + 2; c++) begin
      @(posedge clk); #1;
      if (bus.FrameStart) begin
        if (fs_n == 0) fs_c0 = c; else if (fs_n == 1) fs_c1 = c;
        fs_n++;
      end
      if (hs_prev && !bus.HSync) begin
        if (hs_f1 < 0) hs_f1 = c; else if (hs_f2 < 0) hs_f2 = c;
      end
      if (!bus.HSync && hs_f2 < 0) hs_low++;
      if (vs_prev && !bus.VSync && vs_f < 0) vs_f = c;
      if (!bus.VSync) vs_low++;
      hs_prev = bus.HSync;
      vs_prev = bus.VSync;
      if (c < FRAME) begin
        h = c % LINE; v = c / LINE;
        ea = (h < 640 && v < VA) ? v * 20 + h / 32 : 0;
        if (int'(bus.RdAddress) != ea) addr_bad++;
      end
      for (int k = 0; k < 6; k++) begin
        if (c == a_cyc[k]) begin
          n_cmp++;
          if (int'(bus.RdAddress) != a_exp[k]) begin
            n_bad++; $display("FAIL addr@%0d got %0d want %0d", c, bus.RdAddress, a_exp[k]);
          end
        end
        if (c == p_cyc[k]) begin
          n_cmp++;
          if (rgb !== p_exp[k]) begin
            n_bad++; $display("FAIL pix@%0d got %h want %h", c, rgb, p_exp[k]);
          end
        end
      end
    end
    n_cmp++; if (addr_bad != 0)  begin n_bad++; $display("FAIL addr_scan bad cycles %0d want 0", addr_bad); end
    n_cmp++; if (fs_n != 2)      begin n_bad++; $display("FAIL fs_count got %0d want 2", fs_n); end
    n_cmp++; if (fs_c0 != 2)     begin n_bad++; $display("FAIL fs_first got %0d want 2", fs_c0); end
    n_cmp++; if (fs_c1 != FRAME + 2) begin n_bad++; $display("FAIL fs_second got %0d want %0d", fs_c1, FRAME + 2); end
    n_cmp++; if (hs_f1 != 658)   begin n_bad++; $display("FAIL hs_fall1 got %0d want 658", hs_f1); end
    n_cmp++; if (hs_f2 != 1458)  begin n_bad++; $display("FAIL hs_fall2 got %0d want 1458", hs_f2); end
    n_cmp++; if (hs_low != 96)   begin n_bad++; $display("FAIL hs_width got %0d want 96", hs_low); end
    n_cmp++; if (vs_f != (VA + VFP) * LINE + 2) begin n_bad++; $display("FAIL vs_fall got %0d want %0d", vs_f, (VA + VFP) * LINE + 2); end
    n_cmp++; if (vs_low != 1600) begin n_bad++; $display("FAIL vs_width got %0d want 1600", vs_low); end
  endtask

  task automatic test_solid_fill();
    int act_bad = 0, blk_bad = 0;
    int p, h, v;
    force_ones = 1'b1;
    do_reset();
    for (int c = 1; c <= FRAME + 1; c++) begin
      @(posedge clk); #1;
      if (c >= 2) begin
        p = c - 2; h = p % LINE; v = p / LINE;
        if (h < 640 && v < VA) begin
          if (rgb !== 12'hFFF) act_bad++;
        end else begin
          if (rgb !== 12'h000) blk_bad++;
        end
      end
      if (c == 642) begin
        n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL solid_hblank got %h want 000", rgb); end
      end
      if (c == 23 * LINE + 641) begin
        n_cmp++; if (rgb !== 12'hFFF) begin n_bad++; $display("FAIL solid_last got %h want FFF", rgb); end
      end
      if (c == VA * LINE + 2) begin
        n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL solid_vblank got %h want 000", rgb); end
      end
    end
    n_cmp++; if (act_bad != 0) begin n_bad++; $display("FAIL solid_active bad %0d want 0", act_bad); end
    n_cmp++; if (blk_bad != 0) begin n_bad++; $display("FAIL solid_blank bad %0d want 0", blk_bad); end
  endtask

  task automatic test_mid_reset();
    int fs_c = -1, hs_f = -1, vs_low = 0;
    logic hs_prev = 1'b1;
    force_ones = 1'b1;
    do_reset();
    repeat (10 * LINE + 300) @(posedge clk);
    #1;
    n_cmp++; if (rgb !== 12'hFFF) begin n_bad++; $display("FAIL mid_pre got %h want FFF", rgb); end
    rst = 1'b1;
    #1;
    n_cmp++; if (rgb !== 12'h000)         begin n_bad++; $display("FAIL mid_rgb got %h want 000", rgb); end
    n_cmp++; if (bus.HSync !== 1'b1)      begin n_bad++; $display("FAIL mid_hsync got %b want 1", bus.HSync); end
    n_cmp++; if (bus.VSync !== 1'b1)      begin n_bad++; $display("FAIL mid_vsync got %b want 1", bus.VSync); end
    n_cmp++; if (bus.FrameStart !== 1'b0) begin n_bad++; $display("FAIL mid_fs got %b want 0", bus.FrameStart); end
    n_cmp++; if (bus.RdAddress !== 14'd0) begin n_bad++; $display("FAIL mid_addr got %0d want 0", bus.RdAddress); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 700; c++) begin
      @(posedge clk); #1;
      if (bus.FrameStart && fs_c < 0) fs_c = c;
      if (hs_prev && !bus.HSync && hs_f < 0) hs_f = c;
      if (!bus.VSync) vs_low++;
      hs_prev = bus.HSync;
    end
    n_cmp++; if (fs_c != 2)   begin n_bad++; $display("FAIL mid_fs_after got %0d want 2", fs_c); end
    n_cmp++; if (hs_f != 658) begin n_bad++; $display("FAIL mid_hs_after got %0d want 658", hs_f); end
    n_cmp++; if (vs_low != 0) begin n_bad++; $display("FAIL mid_vs_glitch got %0d want 0", vs_low); end
  endtask

`ifdef LOTR_VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int p_cyc [5] = '{2, 9, 10, 17, 8*800+2};
    logic [11:0] p_exp [5] = '{12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF};
    int a_cyc [3] = '{32, 640, 800};
    int a_exp [3] = '{1, 0, 20};
    force_ones = 1'b0;
    tps = 1'b1;
    do_reset();
    for (int c = 1; c <= 8 * LINE + 2; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
        if (c == p_cyc[k]) begin
          n_cmp++;
          if (rgb !== p_exp[k]) begin n_bad++; $display("FAIL pat@%0d got %h want %h", c, rgb, p_exp[k]); end
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (c == a_cyc[k]) begin
          n_cmp++;
          if (int'(bus.RdAddress) != a_exp[k]) begin
            n_bad++; $display("FAIL pat_addr@%0d got %0d want %0d", c, bus.RdAddress, a_exp[k]);
          end
        end
      end
    end
    tps = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 9600; i++) mem[i] = '0;
    mem[0] = 32'h0000_0001;
    mem[1] = 32'h8000_0000;
    test_reset();
    test_timing_and_fetch();
    test_solid_fill();
    test_mid_reset();
`ifdef LOTR_VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fetch_ctrl.md
Name: vga_fetch_ctrl

Overview:
- Display-side reader for the VGA frame buffer.
- Generates 640x480@60 timing from a 25 MHz pixel clock and fetches 32-bit words from the frame buffer's synchronous read port.
- Serialises each word at 1 bpp (80 bytes per line, 9600 words per frame) to 4:4:4 RGB with HSync/VSync.
- Sits between the frame buffer's read port and the board VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, HSync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, VSync pulse width in lines
- V_BP, 33, vertical back porch in lines
- FG_COLOR, 12'hFFF, {R,G,B} colour driven for a pixel bit of 1
- BG_COLOR, 12'h000, {R,G,B} colour driven for a pixel bit of 0

Ports:
- QClk  in  1  pixel clock, 25 MHz; all state on rising edge
- RstQnnnH  in  1  asynchronous reset, active-high
- RdAddress  out  14  word address to the frame buffer read port
- RdData  in  32  read data, valid one QClk after RdAddress
- VgaR  out  4  red
- VgaG  out  4  green
- VgaB  out  4  blue
- HSync  out  1  horizontal sync, active-low
- VSync  out  1  vertical sync, active-low
- FrameStart  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Single clock QClk. Reset RstQnnnH is asynchronous and active-high.
- Counters:
  - HCnt runs 0..799 (H_TOTAL = sum of the H_* parameters) and wraps to 0.
  - VCnt increments when HCnt wraps; it runs 0..524 and wraps to 0.
  - Reset value of both is 0.
- Raw, stage-0 signals:
  - Active = (HCnt < H_ACTIVE) && (VCnt < V_ACTIVE).
  - HSyncRaw low while H_ACTIVE+H_FP <= HCnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - VSyncRaw low while VCnt is 490..491.
- Fetch (combinational from the registered counters):
  - When Active: RdAddress = VCnt*20 + HCnt[9:5].
  - Compute VCnt*20 as (VCnt<<4)+(VCnt<<2) at 14-bit width. Maximum is 479*20+19 = 9599; no overflow.
  - RdAddress is held constant for all 32 pixels of a word group, so RdData stays stable across the group.
  - When not Active: RdAddress = 0.
- Stage 1 (registered):
  - Registers h1 = HCnt[4:0], plus Active, HSyncRaw, VSyncRaw and the (0,0) flag.
  - Selected pixel bit = RdData[h1]. Bit 0 is the leftmost pixel of the word.
- Stage 2 (output registers):
  - When stage-1 Active is set, RGB = bit ? FG_COLOR : BG_COLOR; otherwise RGB = 12'h000.
  - HSync, VSync and FrameStart are delayed identically to the pixel data.
  - Total latency from counter value (h,v) to pins is exactly 2 QClk. Sync-to-pixel alignment is therefore identical to the raw timing.
- Reset values of outputs: VgaR/G/B = 0, HSync = 1, VSync = 1, FrameStart = 0, RdAddress = 0.
  - Stage registers clear to Active = 0 and syncs inactive.
- Reset mid-frame:
  - Output goes to the reset values immediately (asynchronously).
  - After release the frame restarts at (0,0). No partial line is emitted and no glitch pulse appears on HSync/VSync.
- RdData outside the active window is ignored. Blanking is black regardless of RdData.
- Line wrap and frame wrap each take one cycle; no extra idle cycle is inserted.

Optional Feature:
- Macro: LOTR_VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input port TestPatSel (1 bit).
  - When TestPatSel=1, the stage-1 pixel bit = HCnt[3] ^ VCnt[3] (8x8 checkerboard), taken from the delayed counters. RdData is ignored.
  - Timing, latency and RdAddress are unchanged.
- Not defined: the port is absent and the pixel bit always comes from RdData.

Decomposition:
- lotr_pkg:
  - Timing localparams H_TOTAL = 800 and V_TOTAL = 525, plus the sync start/end constants.
  - VGA_WORDS_PER_LINE = 20 and VGA_ADDR_W = 14.
  - A typedef t_vga_rgb, a struct of three 4-bit fields.
- Sub-module vga_sync_gen:
  - Contains HCnt/VCnt, Active and the raw syncs.
  - Exports the counters.
- vga_fetch_ctrl contains the address generation and the two-stage output pipeline.

Test Plan:
- Release reset, run one frame:
  - First HSync falling edge at cycle 658 (656+2), period 800, low for 96 cycles.
  - VSync low for 1600 cycles starting at cycle 490*800+2.
  - FrameStart pulses at cycles 2 and 420002.
- Monitor RdAddress:
  - Line 0: 0 for HCnt 0..31, 1 for HCnt 32..63, up to 19.
  - Line 1 starts at 20. Line 479, HCnt 639 gives 9599.
  - Blanking gives 0.
- Memory model word0 = 32'h0000_0001, word1 = 32'h8000_0000:
  - Pixel 0 = FFF, pixels 1..31 = 000, pixel 63 = FFF, pixel 32 = 000.
  - Each pixel appears 2 cycles after its HCnt.
- RdData forced to 32'hFFFF_FFFF:
  - RGB = FFF on all 640x480 active pixels.
  - Exactly 000 during both blanking intervals.
- Assert reset at line 200, HCnt 300 for 3 cycles:
  - Outputs at reset values within the same cycle.
  - After release, FrameStart is seen at cycle 2 and the next HSync edge at cycle 658.
- With LOTR_VGA_TEST_PATTERN_EN and TestPatSel=1:
  - Pixels (0..7, 0) = 000, (8..15, 0) = FFF, (0, 8) = FFF.
  - RdAddress sequence is identical to the second scenario.
